mem_arbiter: RTL

//   Two-port arbiter sharing the single unified instruction/data memory between
//   the multicycle ARM core ("cpu") and the program loader/debug port ("ldr").

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (cpu core, loader) and the shared memory.
// The arbiter takes the slave view; the requesters/memory model take the master view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_adr;
  logic [DW-1:0] ldr_wd;
  logic          ldr_ready;
  logic [DW-1:0] ldr_rdata;

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic [1:0]    owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  ldr_req, ldr_we, ldr_adr, ldr_wd,
    input  mem_rd,
    output cpu_ready, cpu_rdata, ldr_ready, ldr_rdata,
    output mem_adr, mem_wd, mem_we, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    output ldr_req, ldr_we, ldr_adr, ldr_wd,
    output mem_rd,
    input  cpu_ready, cpu_rdata, ldr_ready, ldr_rdata,
    input  mem_adr, mem_wd, mem_we, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the unified memory shared by the multicycle core and the loader.
// Owner keeps the bus for at most MAX_BURST accesses while the other port is waiting.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  // Encoding doubles as the owner output: 00 none, 01 cpu, 10 ldr.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_LDR = 2'b10
  } stateT;

  stateT         state, stateNext, otherState;
  logic [CW-1:0] burstCnt, burstNext, burstInc;
  logic          lastLdr, lastLdrNext;
  logic          ownReq, otherReq;
  logic [AW-1:0] memAdr;
  logic [DW-1:0] memWd;
  logic          memWe, cpuReady, ldrReady;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] cnt);
    return (cnt >= BURST_LIMIT) ? BURST_LIMIT : cnt + CW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      burstCnt <= '0;
      lastLdr  <= 1'b1;
    end else begin
      state    <= stateNext;
      burstCnt <= burstNext;
      lastLdr  <= lastLdrNext;
    end
  end

  always_comb begin
    stateNext   = state;
    burstNext   = burstCnt;
    lastLdrNext = lastLdr;
    memAdr      = '0;
    memWd       = '0;
    memWe       = 1'b0;
    cpuReady    = 1'b0;
    ldrReady    = 1'b0;
    ownReq      = (state == GNT_CPU) ? bus.cpu_req : bus.ldr_req;
    otherReq    = (state == GNT_CPU) ? bus.ldr_req : bus.cpu_req;
    otherState  = (state == GNT_CPU) ? GNT_LDR : GNT_CPU;
    burstInc    = satInc(burstCnt);

    case (state)
      IDLE: begin
        burstNext = '0;
        if (bus.cpu_req && (!bus.ldr_req || lastLdr)) stateNext = GNT_CPU;
        else if (bus.ldr_req)                         stateNext = GNT_LDR;
      end
      GNT_CPU: begin
        memAdr   = bus.cpu_adr;
        memWd    = bus.cpu_wd;
        memWe    = bus.cpu_req & bus.cpu_we;
        cpuReady = bus.cpu_req;
      end
      GNT_LDR: begin
        memAdr   = bus.ldr_adr;
        memWd    = bus.ldr_wd;
        memWe    = bus.ldr_req & bus.ldr_we;
        ldrReady = bus.ldr_req;
      end
      default: stateNext = IDLE;
    endcase

    // Burst counter only advances while the other port is actually waiting.
    if (state == GNT_CPU || state == GNT_LDR) begin
      if (ownReq && !(otherReq && burstInc >= BURST_LIMIT)) begin
        burstNext = otherReq ? burstInc : '0;
      end else begin
        burstNext   = '0;
        lastLdrNext = (state == GNT_LDR);
        stateNext   = otherReq ? otherState : IDLE;
      end
    end
  end

  assign bus.mem_adr   = memAdr;
  assign bus.mem_wd    = memWd;
  assign bus.mem_we    = memWe;
  assign bus.cpu_ready = cpuReady;
  assign bus.ldr_ready = ldrReady;
  assign bus.cpu_rdata = bus.mem_rd;
  assign bus.ldr_rdata = bus.mem_rd;
  assign bus.owner     = state;
endmodule
